// File: rtl/btb_plru_sat_if.sv
// Front-end bundle for the branch target buffer: fetch lookups, pipeline
// control, execute-stage resolution bus and the prediction outputs.
interface btb_plru_sat_if #(parameter int PC_W = 32);
  logic            stall;
  logic            flush;
  logic [PC_W-1:0] lookup_pc1;
  logic [PC_W-1:0] lookup_pc2;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            pred_valid;
  logic [PC_W-1:0] pred_target;
  logic            pred_slot0;
  logic            pred_id_valid;
  logic [PC_W-1:0] pred_id_target;
  logic            pred_id_slot0;

  modport master (
    output stall, flush, lookup_pc1, lookup_pc2,
           upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_valid, pred_target, pred_slot0,
           pred_id_valid, pred_id_target, pred_id_slot0
  );

  modport slave (
    input  stall, flush, lookup_pc1, lookup_pc2,
           upd_valid, upd_pc, upd_taken, upd_target,
    output pred_valid, pred_target, pred_slot0,
           pred_id_valid, pred_id_target, pred_id_slot0
  );
endinterface

// File: rtl/btb_plru_sat.sv
// Fully-associative BTB with tree pseudo-LRU replacement and 2-bit direction
// counters. Two fetch lookups per cycle; registered prediction plus a copy
// delayed PIPE_DEPTH stages for decode alignment.
// Optional: define BTB_PERF_CNT_EN to add saturating prediction/redirect counters.
module btb_plru_sat #(
  parameter int ENTRIES    = 16,
  parameter int PC_W       = 32,
  parameter int PIPE_DEPTH = 3
) (
  input  logic clk,
  input  logic resetn,
  btb_plru_sat_if.slave bus
`ifdef BTB_PERF_CNT_EN
  ,
  output logic [31:0] perf_pred_cnt,
  output logic [31:0] perf_redir_cnt
`endif
);
  localparam int IW = $clog2(ENTRIES);

  logic [ENTRIES-1:0]           valid_q, valid_d;
  logic [ENTRIES-1:0][PC_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][PC_W-1:0] tgt_q, tgt_d;
  logic [ENTRIES-1:0][1:0]      ctr_q, ctr_d;
  // Tree nodes in heap order: node n has children 2n and 2n+1, leaves are ENTRIES+idx.
  logic [ENTRIES-1:1]           plru_q, plru_d;

  logic          hit0, hit1, uhit, inv_any, touch_en;
  logic [IW-1:0] idx0, idx1, uidx, inv_idx, victim, aidx, touch_idx;
  int            vic_n;

  // Set every node on the path to entry e so it points away from e.
  function automatic logic [ENTRIES-1:1] touch(input logic [ENTRIES-1:1] bits,
                                               input logic [IW-1:0] e);
    int n;
    n = ENTRIES + int'(e);
    for (int l = 0; l < IW; l++) begin
      bits[n/2] = ~n[0];
      n = n / 2;
    end
    return bits;
  endfunction

  // Associative match: predicting hits per slot, update match, lowest free entry.
  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit0 = 1'b0; idx0 = '0; hit1 = 1'b0; idx1 = '0;
    uhit = 1'b0; uidx = '0; inv_any = 1'b0; inv_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == bus.lookup_pc1 && ctr_q[i][1]) begin hit0 = 1'b1; idx0 = IW'(i); end
      if (valid_q[i] && tag_q[i] == bus.lookup_pc2 && ctr_q[i][1]) begin hit1 = 1'b1; idx1 = IW'(i); end
      if (valid_q[i] && tag_q[i] == bus.upd_pc) begin uhit = 1'b1; uidx = IW'(i); end
      if (!valid_q[i]) begin inv_any = 1'b1; inv_idx = IW'(i); end
    end
  end

  // Walk the PLRU tree from the root to find the replacement victim.
  always_comb begin
    vic_n = 1;
    for (int l = 0; l < IW; l++) vic_n = 2*vic_n + int'(plru_q[vic_n]);
    victim = IW'(vic_n - ENTRIES);
  end

  // Training and replacement-state update; lookups read the pre-update state.
  always_comb begin
    valid_d = valid_q; tag_d = tag_q; tgt_d = tgt_q; ctr_d = ctr_q;
    aidx = inv_any ? inv_idx : victim;
    touch_en = 1'b0; touch_idx = '0;
    if (bus.upd_valid && uhit) begin
      if (bus.upd_taken) begin
        if (ctr_q[uidx] != 2'b11) ctr_d[uidx] = ctr_q[uidx] + 2'd1;
        tgt_d[uidx] = bus.upd_target;
      end else if (ctr_q[uidx] != 2'b00) begin
        ctr_d[uidx] = ctr_q[uidx] - 2'd1;
      end
      touch_en = 1'b1; touch_idx = uidx;
    end else if (bus.upd_valid && bus.upd_taken) begin
      valid_d[aidx] = 1'b1;
      tag_d[aidx]   = bus.upd_pc;
      tgt_d[aidx]   = bus.upd_target;
      ctr_d[aidx]   = 2'b10;
      touch_en = 1'b1; touch_idx = aidx;
    end else if (hit0) begin
      touch_en = 1'b1; touch_idx = idx0;
    end else if (hit1) begin
      touch_en = 1'b1; touch_idx = idx1;
    end
    plru_d = touch_en ? touch(plru_q, touch_idx) : plru_q;
  end

  // BTB state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0; tag_q <= '0; tgt_q <= '0; ctr_q <= '0; plru_q <= '0;
    end else begin
      valid_q <= valid_d; tag_q <= tag_d; tgt_q <= tgt_d; ctr_q <= ctr_d; plru_q <= plru_d;
    end
  end

  // Prediction pipeline: stage 0 is pred_*, stage PIPE_DEPTH is pred_id_*.
  logic [PIPE_DEPTH:0]           vld_pipe_q, vld_pipe_d, slot_pipe_q, slot_pipe_d;
  logic [PIPE_DEPTH:0][PC_W-1:0] tgt_pipe_q, tgt_pipe_d;

  // Flush clears over stall; stall freezes; otherwise shift in the new prediction.
  always_comb begin
    vld_pipe_d = vld_pipe_q; slot_pipe_d = slot_pipe_q; tgt_pipe_d = tgt_pipe_q;
    if (bus.flush) begin
      vld_pipe_d = '0; slot_pipe_d = '0; tgt_pipe_d = '0;
    end else if (!bus.stall) begin
      vld_pipe_d[0]  = hit0 | hit1;
      slot_pipe_d[0] = hit0;
      tgt_pipe_d[0]  = hit0 ? tgt_q[idx0] : (hit1 ? tgt_q[idx1] : '0);
      for (int i = 1; i <= PIPE_DEPTH; i++) begin
        vld_pipe_d[i]  = vld_pipe_q[i-1];
        slot_pipe_d[i] = slot_pipe_q[i-1];
        tgt_pipe_d[i]  = tgt_pipe_q[i-1];
      end
    end
  end

  // Prediction pipeline registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe_q <= '0; slot_pipe_q <= '0; tgt_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d; slot_pipe_q <= slot_pipe_d; tgt_pipe_q <= tgt_pipe_d;
    end
  end

  assign bus.pred_valid     = vld_pipe_q[0];
  assign bus.pred_target    = tgt_pipe_q[0];
  assign bus.pred_slot0     = slot_pipe_q[0];
  assign bus.pred_id_valid  = vld_pipe_q[PIPE_DEPTH];
  assign bus.pred_id_target = tgt_pipe_q[PIPE_DEPTH];
  assign bus.pred_id_slot0  = slot_pipe_q[PIPE_DEPTH];

`ifdef BTB_PERF_CNT_EN
  logic [31:0] perf_pred_q, perf_pred_d, perf_redir_q, perf_redir_d;

  // Saturating counts of issued predictions and unpredicted taken branches.
  always_comb begin
    perf_pred_d  = perf_pred_q;
    perf_redir_d = perf_redir_q;
    if (vld_pipe_q[0] && !bus.stall && perf_pred_q != 32'hFFFF_FFFF)
      perf_pred_d = perf_pred_q + 32'd1;
    if (bus.upd_valid && bus.upd_taken && !(uhit && ctr_q[uidx][1]) &&
        perf_redir_q != 32'hFFFF_FFFF)
      perf_redir_d = perf_redir_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_pred_q <= '0; perf_redir_q <= '0;
    end else begin
      perf_pred_q <= perf_pred_d; perf_redir_q <= perf_redir_d;
    end
  end

  assign perf_pred_cnt  = perf_pred_q;
  assign perf_redir_cnt = perf_redir_q;
`endif
endmodule

// File: tb/tb_btb_plru_sat.sv
// Directed bench for btb_plru_sat: expected predictions are queued as each
// lookup is driven, then popped into a small pipeline model and compared.
module tb_btb_plru_sat;
  localparam int PD = 3;

  typedef struct packed {
    logic        v;
    logic [31:0] t;
    logic        s;
  } pred_t;

  localparam pred_t NONE = '{v: 1'b0, t: 32'h0, s: 1'b0};

  logic clk, resetn;
  btb_plru_sat_if #(.PC_W(32)) bus ();
`ifdef BTB_PERF_CNT_EN
  logic [31:0] perf_pred_cnt, perf_redir_cnt;
`endif

  btb_plru_sat #(.ENTRIES(16), .PC_W(32), .PIPE_DEPTH(PD)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave)
`ifdef BTB_PERF_CNT_EN
    , .perf_pred_cnt(perf_pred_cnt), .perf_redir_cnt(perf_redir_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0, failures = 0;
  pred_t exp_q[$];
  pred_t mp[PD+1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".pred_valid"},     64'(bus.pred_valid),     64'(mp[0].v));
    chk({tag, ".pred_target"},    64'(bus.pred_target),    64'(mp[0].t));
    chk({tag, ".pred_slot0"},     64'(bus.pred_slot0),     64'(mp[0].s));
    chk({tag, ".pred_id_valid"},  64'(bus.pred_id_valid),  64'(mp[PD].v));
    chk({tag, ".pred_id_target"}, 64'(bus.pred_id_target), 64'(mp[PD].t));
    chk({tag, ".pred_id_slot0"},  64'(bus.pred_id_slot0),  64'(mp[PD].s));
  endtask

  task automatic set_look(input logic [31:0] p1, input logic [31:0] p2);
    bus.lookup_pc1 = p1; bus.lookup_pc2 = p2;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    bus.upd_valid = v; bus.upd_pc = pc; bus.upd_taken = tk; bus.upd_target = tg;
  endtask

  // One clock: queue the prediction the current lookups should yield, advance,
  // move it through the model pipe and compare every output.
  task automatic cyc(input string tag, input pred_t e);
    pred_t p;
    exp_q.push_back(e);
    @(posedge clk); #1;
    p = exp_q.pop_front();
    if (bus.flush) begin
      for (int i = 0; i <= PD; i++) mp[i] = NONE;
    end else if (!bus.stall) begin
      for (int i = PD; i >= 1; i--) mp[i] = mp[i-1];
      mp[0] = p;
    end
    chk_outs(tag);
  endtask

  // Reset asserted mid-traffic, held for three cycles, outputs checked throughout.
  task automatic do_reset();
    set_look(32'h1004, 32'h3004);
    set_upd(1'b1, 32'h5004, 1'b1, 32'h6000);
    resetn = 1'b0;
    #1;
    for (int i = 0; i <= PD; i++) mp[i] = NONE;
    chk_outs("reset_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_outs("reset_hold");
    end
    resetn = 1'b1;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    set_look(32'h0, 32'h0);
  endtask

  initial begin
    bus.stall = 1'b0; bus.flush = 1'b0;
    set_look(32'h0, 32'h0);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    do_reset();
    set_look(32'h1000, 32'h0);
    cyc("reset_lookup", NONE);

    // Train; the same-cycle lookup still sees the empty BTB.
    set_upd(1'b1, 32'h1004, 1'b1, 32'h2000);
    set_look(32'h1004, 32'h0);
    cyc("no_bypass", NONE);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    cyc("train_lookup", '{v: 1'b1, t: 32'h2000, s: 1'b1});
    set_look(32'h0, 32'h0);
    for (int i = 0; i < PD; i++) cyc("train_id", NONE);

    // Counter 2 -> 1 -> 0, then one taken -> 1 (still not predicting), another -> 2.
    set_upd(1'b1, 32'h1004, 1'b0, 32'h0);
    cyc("ctr_nt1", NONE);
    cyc("ctr_nt2", NONE);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    set_look(32'h1004, 32'h0);
    cyc("ctr_zero", NONE);
    set_upd(1'b1, 32'h1004, 1'b1, 32'h2000);
    set_look(32'h0, 32'h0);
    cyc("ctr_t1", NONE);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    set_look(32'h1004, 32'h0);
    cyc("ctr_one", NONE);
    set_upd(1'b1, 32'h1004, 1'b1, 32'h2000);
    set_look(32'h0, 32'h0);
    cyc("ctr_t2", NONE);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);

    // Dual hit, slot priority, stall hold and flush-over-stall.
    set_upd(1'b1, 32'h3004, 1'b1, 32'h4000);
    cyc("train_b", NONE);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    set_look(32'h0, 32'h3004);
    cyc("slot1_only", '{v: 1'b1, t: 32'h4000, s: 1'b0});
    set_look(32'h1004, 32'h3004);
    cyc("dual_hit", '{v: 1'b1, t: 32'h2000, s: 1'b1});
    set_look(32'h3004, 32'h0);
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) cyc("stall_hold", '{v: 1'b1, t: 32'h4000, s: 1'b1});
    bus.flush = 1'b1;
    cyc("flush", '{v: 1'b1, t: 32'h4000, s: 1'b1});
    bus.stall = 1'b0; bus.flush = 1'b0;
    set_look(32'h0, 32'h0);
    cyc("post_flush", NONE);

    // Replacement: fill 16 entries, touch PC#0, allocate a 17th. With tree
    // PLRU after in-order fill and a touch of entry 0, the victim is entry 8.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      set_upd(1'b1, 32'h8000 + 32'(k*4), 1'b1, 32'hA000 + 32'(k*4));
      cyc("fill", NONE);
    end
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    set_look(32'h8000, 32'h0);
    cyc("hit_pc0", '{v: 1'b1, t: 32'hA000, s: 1'b1});
    set_look(32'h0, 32'h0);
    set_upd(1'b1, 32'h8040, 1'b1, 32'hB000);
    cyc("alloc17", NONE);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    set_look(32'h8000, 32'h0);
    cyc("pc0_kept", '{v: 1'b1, t: 32'hA000, s: 1'b1});
    set_look(32'h8020, 32'h0);
    cyc("pc8_evicted", NONE);
    set_look(32'h8020, 32'h8004);
    cyc("pc1_kept", '{v: 1'b1, t: 32'hA004, s: 1'b0});
    set_look(32'h8040, 32'h0);
    cyc("pc16_new", '{v: 1'b1, t: 32'hB000, s: 1'b1});
    set_look(32'h0, 32'h0);
    for (int i = 0; i < PD; i++) cyc("drain", NONE);

`ifdef BTB_PERF_CNT_EN
    do_reset();
    set_upd(1'b1, 32'h1004, 1'b1, 32'h2000);
    cyc("perf_redir1", NONE);
    set_upd(1'b1, 32'h3004, 1'b1, 32'h4000);
    cyc("perf_redir2", NONE);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    set_look(32'h1004, 32'h0);
    for (int i = 0; i < 5; i++) cyc("perf_pred", '{v: 1'b1, t: 32'h2000, s: 1'b1});
    set_look(32'h0, 32'h0);
    cyc("perf_idle", NONE);
    chk("perf_pred_cnt",  64'(perf_pred_cnt),  64'd5);
    chk("perf_redir_cnt", 64'(perf_redir_cnt), 64'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
